// File: rtl/filter_pkg.sv
// Shared constants and types for the interpolation filter front end.
package filter_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int PHASE_W        = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_state_t;

    function automatic logic [PHASE_W-1:0] next_phase(
        input logic [PHASE_W-1:0] phase,
        input logic [PHASE_W-1:0] last_phase
    );
        return (phase == last_phase) ? {PHASE_W{1'b0}} : phase + PHASE_W'(1);
    endfunction

endpackage

// File: rtl/rate_tick_gen.sv
// Free-running CLK_DIV counter producing a one-cycle tick on its terminal count.
// Shared by the upsample feeder and the coefficient sequencer.
module rate_tick_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic i_srst,
    output logic o_tick
);

    localparam int                CNT_W   = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Divider counter, wraps at CLK_DIV-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_srst) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tick = (r_cnt == CNT_MAX) && !i_srst;

endmodule

// File: rtl/upsample_feeder.sv
// Zero-insertion upsampler feeding the interpolation delay line.
// Define UPSAMPLE_ZOH_EN for zero-order hold instead of zero insertion.
module upsample_feeder
    import filter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int L          = 4,
    parameter int CLK_DIV    = 25
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_write_EN,
    output logic [PHASE_W-1:0]    o_phase,
    output logic                  o_underrun
);

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(L - 1);

    logic [1:0]            r_rst_sync;
    logic                  w_srst;
    logic                  w_tick;
    logic                  w_accept;
    logic                  w_consume;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_hold_full;
    logic [DATA_WIDTH-1:0] w_fill;
    fsm_state_t            r_state;
    fsm_state_t            w_state_nxt;
    logic [PHASE_W-1:0]    r_phase;
    logic [PHASE_W-1:0]    w_phase_nxt;
    logic [PHASE_W-1:0]    w_ophase_nxt;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic                  w_we_nxt;
    logic                  w_und_nxt;

    // Reset release synchroniser; its output clears the datapath synchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_srst = !r_rst_sync[1];

    rate_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .i_srst (w_srst),
        .o_tick (w_tick)
    );

    assign w_consume = w_tick && r_hold_full && ((r_state == IDLE) || (r_phase == '0));
    assign o_ready   = !r_hold_full || w_consume;
    assign w_accept  = i_valid && o_ready;

    // One-entry hold buffer; a same-cycle accept wins over the consume.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold      <= i_data;
            r_hold_full <= 1'b1;
        end else if (w_consume) begin
            r_hold_full <= 1'b0;
        end else begin
            r_hold_full <= r_hold_full;
        end
    end

`ifdef UPSAMPLE_ZOH_EN
    logic [DATA_WIDTH-1:0] r_last;

    // Last phase-0 sample, repeated on fill phases and on underrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= '0;
        end else if (w_srst) begin
            r_last <= '0;
        end else if (w_consume) begin
            r_last <= r_hold;
        end else begin
            r_last <= r_last;
        end
    end

    assign w_fill = r_last;
`else
    assign w_fill = '0;
`endif

    // Next-state and next-output decode; once running, every tick strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;
        w_ophase_nxt = o_phase;
        w_data_nxt   = o_data;
        w_we_nxt     = 1'b0;
        w_und_nxt    = o_underrun;
        case (r_state)
            IDLE: begin
                if (w_tick && r_hold_full) begin
                    w_state_nxt  = RUN;
                    w_phase_nxt  = PHASE_W'(1);
                    w_ophase_nxt = '0;
                    w_data_nxt   = r_hold;
                    w_we_nxt     = 1'b1;
                end else begin
                    w_state_nxt  = IDLE;
                end
            end
            RUN: begin
                if (w_tick) begin
                    w_we_nxt     = 1'b1;
                    w_ophase_nxt = r_phase;
                    w_phase_nxt  = next_phase(r_phase, LAST_PHASE);
                    if (r_phase != '0) begin
                        w_data_nxt = w_fill;
                    end else if (r_hold_full) begin
                        w_data_nxt = r_hold;
                    end else begin
                        w_data_nxt = w_fill;
                        w_und_nxt  = 1'b1;
                    end
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM state and registered delay-line outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_phase    <= '0;
            o_phase    <= '0;
            o_data     <= '0;
            o_write_EN <= 1'b0;
            o_underrun <= 1'b0;
        end else if (w_srst) begin
            r_state    <= IDLE;
            r_phase    <= '0;
            o_phase    <= '0;
            o_data     <= '0;
            o_write_EN <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            o_phase    <= w_ophase_nxt;
            o_data     <= w_data_nxt;
            o_write_EN <= w_we_nxt;
            o_underrun <= w_und_nxt;
        end
    end

endmodule

// File: tb/tb_upsample_feeder.sv
// Directed bench for upsample_feeder (L=4, CLK_DIV=25); expectations follow UPSAMPLE_ZOH_EN.
module tb_upsample_feeder;

    localparam int DW      = 8;
    localparam int L       = 4;
    localparam int CLK_DIV = 25;
`ifdef UPSAMPLE_ZOH_EN
    localparam bit ZOH = 1'b1;
`else
    localparam bit ZOH = 1'b0;
`endif

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          i_valid = 1'b0;
    logic [DW-1:0] i_data  = '0;
    logic          o_ready;
    logic [DW-1:0] o_data;
    logic          o_write_EN;
    logic [3:0]    o_phase;
    logic          o_underrun;

    always #5 clk = ~clk;

    upsample_feeder #(
        .DATA_WIDTH (DW),
        .L          (L),
        .CLK_DIV    (CLK_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_ready    (o_ready),
        .o_data     (o_data),
        .o_write_EN (o_write_EN),
        .o_phase    (o_phase),
        .o_underrun (o_underrun)
    );

    typedef struct {
        logic signed [7:0] d;
        logic [3:0]        ph;
        logic              und;
        int                cyc;
    } strobe_t;

    strobe_t q[$];
    int      cyc     = 0;
    logic    prev_we = 1'b0;
    int      dbl     = 0;
    int      errors  = 0;
    int      checks  = 0;
    int      base    = 0;

    // Strobe monitor: logs every write strobe with its cycle stamp.
    always @(negedge clk) begin
        cyc     <= cyc + 1;
        prev_we <= o_write_EN;
        if (o_write_EN === 1'b1 && prev_we === 1'b1) dbl <= dbl + 1;
        if (o_write_EN === 1'b1) q.push_back('{$signed(o_data), o_phase, o_underrun, cyc});
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] exp_word(input logic signed [7:0] s, input int ph);
        return (ph == 0 || ZOH) ? 32'(s) : 32'sd0;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", o_data, 0);
        chk("rst_we", o_write_EN, 0);
        chk("rst_phase", o_phase, 0);
        chk("rst_und", o_underrun, 0);
        chk("rst_ready", o_ready, 1);
        rst = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic push(input logic signed [7:0] d, input bit exp_consume, input logic signed [7:0] prev);
        bit got;
        got     = 1'b0;
        i_valid = 1'b1;
        i_data  = d;
        for (int n = 0; n < 200; n++) begin
            if (o_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("push_ready", 32'(got), 1);
        @(negedge clk);
        if (exp_consume) begin
            chk("acc_con_we", o_write_EN, 1);
            chk("acc_con_data", $signed(o_data), 32'(prev));
            chk("acc_con_ready", o_ready, 0);
        end
    endtask

    task automatic wait_strobes(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (q.size() >= base + n) break;
        end
        @(negedge clk);
        chk("strobe_timeout", (q.size() >= base + n) ? 1 : 0, 1);
    endtask

    task automatic idle_check(input string tag);
        base = q.size();
        repeat (200) @(negedge clk);
        chk({tag, "_strobes"}, q.size() - base, 0);
        chk({tag, "_und"}, o_underrun, 0);
        chk({tag, "_ready"}, o_ready, 1);
    endtask

    logic signed [7:0] smp [3];

    initial begin
        smp[0] = 8'sd10;
        smp[1] = -8'sd5;
        smp[2] = 8'sd127;
        @(negedge clk);

        // Reset then idle.
        do_reset();
        idle_check("idle");

        // Single sample, then underrun at the next phase 0.
        base = q.size();
        push(8'sd37, 1'b0, 8'sd0);
        i_valid = 1'b0;
        wait_strobes(5, 400);
        for (int k = 0; k < 4; k++) begin
            chk("single_data", q[base+k].d, exp_word(8'sd37, k));
            chk("single_phase", q[base+k].ph, k);
            chk("single_und", q[base+k].und, 0);
            if (k > 0) chk("single_gap", q[base+k].cyc - q[base+k-1].cyc, CLK_DIV);
        end
        chk("urun_data", q[base+4].d, exp_word(8'sd37, 1));
        chk("urun_phase", q[base+4].ph, 0);
        chk("urun_flag", q[base+4].und, 1);
        repeat (10) @(negedge clk);
        chk("hold_we", o_write_EN, 0);
        chk("hold_data", $signed(o_data), 32'(q[q.size()-1].d));
        chk("urun_sticky", o_underrun, 1);

        // Continuous stream with accept/consume overlap.
        do_reset();
        base = q.size();
        push(smp[0], 1'b0, 8'sd0);
        push(smp[1], 1'b1, smp[0]);
        push(smp[2], 1'b1, smp[1]);
        i_valid = 1'b0;
        wait_strobes(13, 700);
        for (int k = 0; k < 12; k++) begin
            chk("stream_data", q[base+k].d, exp_word(smp[k/4], k % 4));
            chk("stream_phase", q[base+k].ph, k % 4);
            chk("stream_und", q[base+k].und, 0);
            if (k > 0) chk("stream_gap", q[base+k].cyc - q[base+k-1].cyc, CLK_DIV);
        end
        chk("stream_urun_data", q[base+12].d, exp_word(smp[2], 1));
        chk("stream_urun_flag", q[base+12].und, 1);

        // Mid-run asynchronous reset at phase 2.
        do_reset();
        base = q.size();
        push(8'sd37, 1'b0, 8'sd0);
        i_valid = 1'b0;
        wait_strobes(3, 300);
        chk("pre_rst_phase", o_phase, 2);
        #2 rst = 1'b0;
        #1;
        chk("async_data", o_data, 0);
        chk("async_we", o_write_EN, 0);
        chk("async_phase", o_phase, 0);
        chk("async_und", o_underrun, 0);
        chk("async_ready", o_ready, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle_check("post_rst");

        chk("double_strobe", dbl, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
